pwm_duty_capture: RTL and testbench

Receive-side counterpart of the team's 8-bit PWM generator. Samples an asynchronous PWM waveform (`pwm_in`), measures high time and period in `clk_pwm_out` cycles, and recovers the 8-bit duty code the generator was driven with. Flags stuck-high, stuck-low and off-nominal period. Sits in the feedback/loopback path of the PWM/LED drive chain for self-test and closed-loop monitoring.

---
 rtl/pwm_duty_capture.sv | 209 ++++++++++++++++++++
 tb/tb_pwm_duty_capture.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture: recovers the 8-bit duty code, high time and period
// of an asynchronous PWM input; flags stuck-high/low and bad period.
// Ports:
//   clk_pwm_out - sampling and measurement clock
//   rst_n       - asynchronous active-low reset
//   pwm_in      - PWM waveform, asynchronous to clk_pwm_out
//   duty_data   - recovered duty code (high cycles - 1, saturated at 255)
//   high_cnt    - last measured high time in cycles
//   period_cnt  - last measured period in cycles
//   duty_valid  - one-cycle pulse when the outputs above update
//   stuck_hi    - input held high for TIMEOUT cycles
//   stuck_lo    - input held low for TIMEOUT cycles
//   period_err  - last measured period differs from NOMINAL_PERIOD
module pwm_duty_capture #(
  parameter int unsigned NOMINAL_PERIOD = 256,
  parameter int unsigned TIMEOUT        = 512
) (
  input  logic        clk_pwm_out,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic [7:0]  duty_data,
  output logic [15:0] high_cnt,
  output logic [15:0] period_cnt,
  output logic        duty_valid,
  output logic        stuck_hi,
  output logic        stuck_lo,
  output logic        period_err
);

  localparam logic [15:0] NOM_P  = 16'(NOMINAL_PERIOD);
  localparam logic [15:0] TMO_M1 = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ACQ,
    HIGH,
    LOW,
    STUCK
  } state_e;

  logic        s0_q;
  logic        s1_q;
  logic        s2_q;
  state_e      state_q;
  state_e      state_d;
  logic [15:0] pcnt_q;
  logic [15:0] pcnt_d;
  logic [15:0] hcnt_q;
  logic [15:0] hcnt_d;
  logic [15:0] tcnt_q;
  logic [15:0] tcnt_d;
  logic [7:0]  duty_q;
  logic [7:0]  duty_d;
  logic [15:0] high_q;
  logic [15:0] high_d;
  logic [15:0] per_q;
  logic [15:0] per_d;
  logic        valid_q;
  logic        valid_d;
  logic        shi_q;
  logic        shi_d;
  logic        slo_q;
  logic        slo_d;
  logic        perr_q;
  logic        perr_d;

  logic        rise;
  logic        fall;
  logic        publish;
  logic        tmo_hit;
  logic [7:0]  duty_sat;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    rise = s1_q & ~s2_q;
    fall = ~s1_q & s2_q;
    publish = (state_q == LOW) && rise;
    // a rise restarts the watchdog, so it wins over timeout
    tmo_hit = (state_q != STUCK) && !rise
            && (tcnt_q == TMO_M1);
    if (hcnt_q > 16'd255) begin
      duty_sat = 8'hFF;
    end else if (hcnt_q == 16'd0) begin
      duty_sat = 8'h00;
    end else begin
      duty_sat = 8'(hcnt_q - 16'd1);
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    hcnt_d  = hcnt_q;
    tcnt_d  = tcnt_q;
    unique case (1'b1)
      rise: begin
        state_d = HIGH;
        pcnt_d  = 16'd1;
        hcnt_d  = 16'd1;
        tcnt_d  = 16'd0;
      end
      tmo_hit: begin
        state_d = STUCK;
        tcnt_d  = sat_inc(tcnt_q);
      end
      default: begin
        unique case (state_q)
          ACQ: begin
            tcnt_d = sat_inc(tcnt_q);
          end
          HIGH, LOW: begin
            pcnt_d = sat_inc(pcnt_q);
            tcnt_d = sat_inc(tcnt_q);
            if (s1_q) begin
              hcnt_d = sat_inc(hcnt_q);
            end
            if (state_q == HIGH && fall) begin
              state_d = LOW;
            end
          end
          STUCK: begin
          end
          default: begin
            state_d = ACQ;
          end
        endcase
      end
    endcase
  end

  always_comb begin
    duty_d  = duty_q;
    high_d  = high_q;
    per_d   = per_q;
    shi_d   = shi_q;
    slo_d   = slo_q;
    perr_d  = perr_q;
    valid_d = 1'b0;
    unique case (1'b1)
      publish: begin
        duty_d  = duty_sat;
        high_d  = hcnt_q;
        per_d   = pcnt_q;
        perr_d  = (pcnt_q != NOM_P);
        shi_d   = 1'b0;
        slo_d   = 1'b0;
        valid_d = 1'b1;
      end
      tmo_hit: begin
        duty_d  = s1_q ? 8'hFF : 8'h00;
        high_d  = 16'd0;
        per_d   = 16'd0;
        perr_d  = 1'b0;
        shi_d   = s1_q;
        slo_d   = ~s1_q;
        valid_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_pwm_out or negedge rst_n) begin
    if (!rst_n) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= ACQ;
      pcnt_q  <= 16'd0;
      hcnt_q  <= 16'd0;
      tcnt_q  <= 16'd0;
      duty_q  <= 8'd0;
      high_q  <= 16'd0;
      per_q   <= 16'd0;
      valid_q <= 1'b0;
      shi_q   <= 1'b0;
      slo_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      s0_q    <= pwm_in;
      s1_q    <= s0_q;
      s2_q    <= s1_q;
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      hcnt_q  <= hcnt_d;
      tcnt_q  <= tcnt_d;
      duty_q  <= duty_d;
      high_q  <= high_d;
      per_q   <= per_d;
      valid_q <= valid_d;
      shi_q   <= shi_d;
      slo_q   <= slo_d;
      perr_q  <= perr_d;
    end
  end

  assign duty_data  = duty_q;
  assign high_cnt   = high_q;
  assign period_cnt = per_q;
  assign duty_valid = valid_q;
  assign stuck_hi   = shi_q;
  assign stuck_lo   = slo_q;
  assign period_err = perr_q;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// tb_pwm_duty_capture: directed vectors for pwm_duty_capture.
// Table of steady frames plus stuck, recovery and reset sequences.
module tb_pwm_duty_capture;

  logic        clk;
  logic        rst_n;
  logic        pwm_in;
  logic [7:0]  duty_data;
  logic [15:0] high_cnt;
  logic [15:0] period_cnt;
  logic        duty_valid;
  logic        stuck_hi;
  logic        stuck_lo;
  logic        period_err;

  int n_chk;
  int n_fail;
  int vcount;

  pwm_duty_capture #(
    .NOMINAL_PERIOD(256),
    .TIMEOUT(512)
  ) dut (
    .clk_pwm_out(clk),
    .rst_n(rst_n),
    .pwm_in(pwm_in),
    .duty_data(duty_data),
    .high_cnt(high_cnt),
    .period_cnt(period_cnt),
    .duty_valid(duty_valid),
    .stuck_hi(stuck_hi),
    .stuck_lo(stuck_lo),
    .period_err(period_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (duty_valid === 1'b1) vcount++;
  end

  typedef struct {
    int hi;
    int per;
    int n;
    int duty;
    int hc;
    int pc;
    int perr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int c0;
    c0 = vcount;
    for (int f = 0; f < v.n; f++) begin
      drive(1'b1, v.hi);
      drive(1'b0, v.per - v.hi);
    end
    drive(1'b1, 5);
    $display("vector %0d: hi=%0d per=%0d", idx, v.hi, v.per);
    chk("valid_count", vcount - c0, v.n);
    chk("duty_data", {24'd0, duty_data}, v.duty);
    chk("high_cnt", {16'd0, high_cnt}, v.hc);
    chk("period_cnt", {16'd0, period_cnt}, v.pc);
    chk("period_err", {31'd0, period_err}, v.perr);
    chk("stuck_hi", {31'd0, stuck_hi}, 0);
    chk("stuck_lo", {31'd0, stuck_lo}, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_duty"}, {24'd0, duty_data}, 0);
    chk({tag, "_high"}, {16'd0, high_cnt}, 0);
    chk({tag, "_period"}, {16'd0, period_cnt}, 0);
    chk({tag, "_valid"}, {31'd0, duty_valid}, 0);
    chk({tag, "_shi"}, {31'd0, stuck_hi}, 0);
    chk({tag, "_slo"}, {31'd0, stuck_lo}, 0);
    chk({tag, "_perr"}, {31'd0, period_err}, 0);
  endtask

  initial begin
    int c0;
    n_chk  = 0;
    n_fail = 0;
    vcount = 0;
    vecs[0] = '{hi: 11,  per: 256, n: 3, duty: 10,  hc: 11,  pc: 256, perr: 0};
    vecs[1] = '{hi: 1,   per: 256, n: 2, duty: 0,   hc: 1,   pc: 256, perr: 0};
    vecs[2] = '{hi: 201, per: 256, n: 2, duty: 200, hc: 201, pc: 256, perr: 0};
    vecs[3] = '{hi: 300, per: 400, n: 2, duty: 255, hc: 300, pc: 400, perr: 1};
    vecs[4] = '{hi: 255, per: 256, n: 2, duty: 254, hc: 255, pc: 256, perr: 0};
    vecs[5] = '{hi: 128, per: 200, n: 2, duty: 127, hc: 128, pc: 200, perr: 1};
    vecs[6] = '{hi: 1,   per: 2,   n: 4, duty: 0,   hc: 1,   pc: 2,   perr: 1};

    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // held low from reset: stuck_lo at the 512th edge
    drive(1'b0, 510);
    chk("lo_early_valid", vcount, 0);
    chk("lo_early_slo", {31'd0, stuck_lo}, 0);
    drive(1'b0, 4);
    chk("lo_valid", vcount, 1);
    chk("lo_slo", {31'd0, stuck_lo}, 1);
    chk("lo_shi", {31'd0, stuck_hi}, 0);
    chk("lo_duty", {24'd0, duty_data}, 0);
    chk("lo_period", {16'd0, period_cnt}, 0);
    drive(1'b0, 600);
    chk("lo_no_repub", vcount, 1);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
    end

    // constant high after one rise
    drive(1'b0, 20);
    drive(1'b1, 4);
    c0 = vcount;
    drive(1'b1, 500);
    chk("hi_early_valid", vcount - c0, 0);
    drive(1'b1, 20);
    chk("hi_valid", vcount - c0, 1);
    chk("hi_shi", {31'd0, stuck_hi}, 1);
    chk("hi_slo", {31'd0, stuck_lo}, 0);
    chk("hi_duty", {24'd0, duty_data}, 255);
    chk("hi_high", {16'd0, high_cnt}, 0);
    chk("hi_period", {16'd0, period_cnt}, 0);
    chk("hi_perr", {31'd0, period_err}, 0);
    drive(1'b1, 200);
    chk("hi_no_repub", vcount - c0, 1);
    drive(1'b0, 50);
    run_vec(vecs[0], 7);

    // reset in the middle of a high phase
    drive(1'b1, 3);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    drive(1'b1, 3);
    rst_n = 1'b1;
    c0 = vcount;
    drive(1'b1, 11);
    drive(1'b0, 245);
    chk("rst_first_rise", vcount - c0, 0);
    drive(1'b1, 11);
    drive(1'b0, 245);
    chk("rst_second_rise", vcount - c0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
